// File: rtl/bound_flasher_ctrl.sv
// Bound flasher sequencer: drives a 16-lamp thermometer bar through the
// pattern up-to-6, down-to-0, up-to-11, down-to-5, up-to-16, down-to-0.
// One lamp step per tick; the tick is divided down by STEP_DIV.
// Optional feature macro: BOUND_FLASHER_KICKBACK_EN. When it is defined, flick
// during UP10/UP15 at level 6 or 11 kicks the bar back to the preceding
// descent.
module bound_flasher_ctrl #(
  parameter int STEP_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick,
  output logic [2:0]  main_state,
  output logic [2:0]  main_state_n,
  output logic [15:0] lamp,
  output logic        busy
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    UP5     = 3'd1,
    DN0A    = 3'd2,
    UP10    = 3'd3,
    DN5     = 3'd4,
    UP15    = 3'd5,
    DN0B    = 3'd6,
    ILLEGAL = 3'd7
  } state_t;

  localparam logic [7:0] PS_LAST = 8'(STEP_DIV - 1);

  state_t      state_reg, state_next;
  logic [4:0]  lvl_reg, lvl_next;
  logic [7:0]  ps_reg, ps_next;
  logic [15:0] lamp_reg, lamp_next;
  logic        tick;

  // Step strobe: free-running at full rate, otherwise the prescaler wrap.
  generate
    if (STEP_DIV == 1) begin : g_tick_full
      assign tick = 1'b1;
    end else begin : g_tick_div
      assign tick = (state_reg != INIT) && (ps_reg == PS_LAST);
    end
  endgenerate

  // Prescaler is parked at zero in INIT so the first step after a flick
  // always lands a full STEP_DIV cycles after leaving INIT.
  always_comb begin
    ps_next = ps_reg + 8'd1;
    if (state_reg == INIT || ps_reg == PS_LAST) begin
      ps_next = '0;
    end
  end

`ifdef BOUND_FLASHER_KICKBACK_EN
  logic kick;
  assign kick = flick && (lvl_reg == 5'd6 || lvl_reg == 5'd11);
`endif

  // Next-state and next-level logic; the level is held on the tick that
  // moves the sequencer into its next phase.
  always_comb begin
    state_next = state_reg;
    lvl_next   = lvl_reg;
    case (state_reg)
      INIT: begin
        if (flick) state_next = UP5;
      end
      UP5: begin
        if (tick) begin
          if (lvl_reg == 5'd6) state_next = DN0A;
          else                 lvl_next   = lvl_reg + 5'd1;
        end
      end
      DN0A: begin
        if (tick) begin
          if (lvl_reg == 5'd0) state_next = UP10;
          else                 lvl_next   = lvl_reg - 5'd1;
        end
      end
      UP10: begin
        if (tick) begin
`ifdef BOUND_FLASHER_KICKBACK_EN
          if (kick)                   state_next = DN0A;
          else if (lvl_reg == 5'd11)  state_next = DN5;
          else                        lvl_next   = lvl_reg + 5'd1;
`else
          if (lvl_reg == 5'd11) state_next = DN5;
          else                  lvl_next   = lvl_reg + 5'd1;
`endif
        end
      end
      DN5: begin
        if (tick) begin
          if (lvl_reg == 5'd5) state_next = UP15;
          else                 lvl_next   = lvl_reg - 5'd1;
        end
      end
      UP15: begin
        if (tick) begin
`ifdef BOUND_FLASHER_KICKBACK_EN
          if (kick)                   state_next = DN5;
          else if (lvl_reg == 5'd16)  state_next = DN0B;
          else                        lvl_next   = lvl_reg + 5'd1;
`else
          if (lvl_reg == 5'd16) state_next = DN0B;
          else                  lvl_next   = lvl_reg + 5'd1;
`endif
        end
      end
      DN0B: begin
        if (tick) begin
          if (lvl_reg == 5'd0) state_next = flick ? UP5 : INIT;
          else                 lvl_next   = lvl_reg - 5'd1;
        end
      end
      default: begin
        state_next = INIT;
        lvl_next   = '0;
      end
    endcase
  end

  // Thermometer decode of the upcoming level so lamp stays aligned with lvl.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lamp
      assign lamp_next[gi] = (lvl_next > 5'(gi));
    end
  endgenerate

  // State, level, prescaler and lamp registers; reset is a full abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= INIT;
      lvl_reg   <= '0;
      ps_reg    <= '0;
      lamp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lvl_reg   <= lvl_next;
      ps_reg    <= ps_next;
      lamp_reg  <= lamp_next;
    end
  end

  assign main_state   = state_reg;
  assign main_state_n = state_next;
  assign lamp         = lamp_reg;
  assign busy         = (state_reg != INIT);

endmodule
